// File: rtl/wallace_tree_mac_pipelined.sv
// 3-stage pipelined unsigned Wallace-tree MAC with an optional OR-compressed
// approximation of the low product columns and full valid/ready backpressure.
module wallace_tree_mac_pipelined #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 2*WIDTH+8,
    parameter int APPROX_COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    input  logic                 in_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);
    localparam int STAGES = 3;
    localparam int PW     = 2*WIDTH;
    // WIDTH partial-product rows plus one row holding the OR-compressed low
    // columns; two spare rows keep the 3-row grouping index in range.
    localparam int R0     = WIDTH + 1;
    localparam int RMAX   = R0 + 2;

    typedef logic [RMAX-1:0][PW-1:0] rows_t;

    function automatic int rows_after(input int n);
        return (n > 2) ? 2*(n/3) + n%3 : n;
    endfunction

    localparam int R1 = rows_after(R0);

    // One Wallace layer: every full group of three rows becomes a sum row and
    // a shifted carry row; leftover rows pass straight through.
    function automatic rows_t csa_layer(input rows_t r, input int n);
        rows_t o;
        int    k;
        o = '0;
        k = 0;
        if (n <= 2) begin
            o = r;
        end else begin
            for (int i = 0; i < R0; i += 3) begin
                if (i + 2 < n) begin
                    o[k]   = r[i] ^ r[i+1] ^ r[i+2];
                    o[k+1] = ((r[i] & r[i+1]) | (r[i] & r[i+2]) | (r[i+1] & r[i+2])) << 1;
                    k      = k + 2;
                end else begin
                    for (int j = i; j < i + 3; j++) begin
                        if (j < n) begin
                            o[k] = r[j];
                            k    = k + 1;
                        end
                    end
                end
            end
        end
        return o;
    endfunction

    logic                 adv;
    logic [STAGES:1]      vld_pipe;
    logic [2:1]           clr_pipe;
    rows_t                pp, s1_next, s1_rows, s2_rows;
    int                   s2_n;
    logic [PW-1:0]        s2_sum, s2_carry, prod;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   prod_ext, acc_sum;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // Approximated columns never enter the tree, so no carry can cross the
    // APPROX_COLS boundary; their OR lands in a row the tree adds exactly.
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (in_approx && (i + j) < APPROX_COLS)
                    pp[R0-1][i+j] = pp[R0-1][i+j] | (in_a[i] & in_b[j]);
                else
                    pp[i][i+j] = in_a[i] & in_b[j];
            end
        end
        s1_next = csa_layer(pp, R0);
    end

    always_comb begin
        s2_rows = s1_rows;
        s2_n    = R1;
        for (int l = 0; l < WIDTH; l++) begin
            s2_rows = csa_layer(s2_rows, s2_n);
            s2_n    = rows_after(s2_n);
        end
    end

    always_comb begin
        prod              = s2_sum + s2_carry;
        prod_ext          = '0;
        prod_ext[PW-1:0]  = prod;
        acc_base          = clr_pipe[2] ? '0 : out_acc;
        acc_sum           = {1'b0, acc_base} + prod_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            clr_pipe <= '0;
            s1_rows  <= '0;
            s2_sum   <= '0;
            s2_carry <= '0;
            out_prod <= '0;
            out_acc  <= '0;
            out_ovf  <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            clr_pipe <= {clr_pipe[1], in_clear};
            s1_rows  <= s1_next;
            s2_sum   <= s2_rows[0];
            s2_carry <= s2_rows[1];
            if (vld_pipe[2]) begin
                out_prod <= prod;
                out_acc  <= acc_sum[ACC_WIDTH-1:0];
                out_ovf  <= clr_pipe[2] ? acc_sum[ACC_WIDTH] : (out_ovf | acc_sum[ACC_WIDTH]);
            end
        end
    end
endmodule

// File: tb/tb_wallace_tree_mac_pipelined.sv
// Bench for wallace_tree_mac_pipelined: directed plus randomized traffic,
// checked every cycle against a column-counting arithmetic reference.
module tb_wallace_tree_mac_pipelined;
    localparam int W  = 8;
    localparam int AC = 4;
    localparam int PW = 2*W;
    localparam int AW = 2*W+8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_approx = 1'b0;
    logic          in_clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_prod;
    logic [AW-1:0] out_acc;
    logic          out_ovf;

    wallace_tree_mac_pipelined #(.WIDTH(W), .ACC_WIDTH(AW), .APPROX_COLS(AC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_clear(in_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference product: exact, or per-column bit counts with low columns OR-ed.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic ap);
        int     cnt [PW];
        longint s;
        if (!ap) return PW'(a) * PW'(b);
        foreach (cnt[c]) cnt[c] = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                cnt[i+j] += int'(a[i] & b[j]);
        s = 0;
        for (int c = 0; c < PW; c++) begin
            if (c < AC) s += (cnt[c] != 0) ? (longint'(1) << c) : 0;
            else        s += longint'(cnt[c]) << c;
        end
        return s[PW-1:0];
    endfunction

    typedef struct {
        logic [PW-1:0] prod;
        logic [AW-1:0] acc;
        logic          ovf;
        int            acyc;
    } exp_t;

    exp_t          q[$];
    logic [PW-1:0] obs_prod[$];
    logic [AW-1:0] obs_acc[$];
    logic          obs_ovf[$];
    logic [AW-1:0] acc_m = '0;
    logic          ovf_m = 1'b0;
    logic [AW-1:0] last_acc = '0;
    logic          held = 1'b0, head_seen = 1'b0;
    logic [PW-1:0] h_prod;
    logic [AW-1:0] h_acc;
    logic          h_ovf;
    int            last_stall = -1;
    int            n_stall = 0;

    logic          rdy_rand = 1'b0;
    int            st_lo = 0, st_hi = 0;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : !(cyc >= st_lo && cyc < st_hi);
    end

    // Single compare process: model update on accept, scoreboard on output.
    always @(negedge clk) begin
        exp_t          e;
        logic [AW:0]   s;
        logic [PW-1:0] p;
        if (!rst_n) begin
            q.delete();
            acc_m = '0; ovf_m = 1'b0; last_acc = '0;
            held = 1'b0; head_seen = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (last_stall < e.acyc) chk("latency", cyc - e.acyc, 3);
                    end
                    if (held) begin
                        chk("stall_hold_prod", out_prod, h_prod);
                        chk("stall_hold_acc", out_acc, h_acc);
                        chk("stall_hold_ovf", out_ovf, h_ovf);
                    end
                    if (!out_ready) begin
                        held = 1'b1; h_prod = out_prod; h_acc = out_acc; h_ovf = out_ovf;
                        last_stall = cyc; n_stall++;
                    end else begin
                        chk("out_prod", out_prod, e.prod);
                        chk("out_acc", out_acc, e.acc);
                        chk("out_ovf", out_ovf, e.ovf);
                        obs_prod.push_back(out_prod);
                        obs_acc.push_back(out_acc);
                        obs_ovf.push_back(out_ovf);
                        last_acc = e.acc;
                        void'(q.pop_front());
                        head_seen = 1'b0; held = 1'b0;
                    end
                end
            end else begin
                chk("acc_idle", out_acc, last_acc);
            end
            if (in_valid && in_ready) begin
                p = ref_prod(in_a, in_b, in_approx);
                s = {1'b0, (in_clear ? {AW{1'b0}} : acc_m)} + (AW+1)'(p);
                acc_m = s[AW-1:0];
                ovf_m = in_clear ? s[AW] : (ovf_m | s[AW]);
                e.prod = p; e.acc = acc_m; e.ovf = ovf_m; e.acyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ap, input logic cl);
        int   n;
        logic r;
        n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap; in_clear = cl;
        do begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 200);
        if (!r) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (obs_prod.size() < n && t < 1000) begin @(posedge clk); #1; t++; end
        if (obs_prod.size() < n) chk("wait_output_timeout", obs_prod.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_prod", out_prod, 0);
        chk("reset_out_acc", out_acc, 0);
        chk("reset_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        idle(1);

        chk("model_pin_3x3_approx", ref_prod(8'd3, 8'd3, 1'b1), 7);
        chk("model_pin_ff_approx", ref_prod(8'd255, 8'd255, 1'b1), 64991);

        // Exact full-scale product with clear
        base = obs_prod.size();
        send(8'd255, 8'd255, 1'b0, 1'b1);
        wait_obs(base + 1);
        chk("exact_prod", obs_prod[base], 65025);
        chk("exact_acc", obs_acc[base], 65025);
        chk("exact_ovf", obs_ovf[base], 0);

        // Approximate mode
        base = obs_prod.size();
        send(8'd3, 8'd3, 1'b1, 1'b1);
        send(8'd255, 8'd255, 1'b1, 1'b0);
        send(8'd3, 8'd5, 1'b1, 1'b0);
        wait_obs(base + 3);
        chk("approx_3x3_prod", obs_prod[base], 7);
        chk("approx_3x3_acc", obs_acc[base], 7);
        chk("approx_ff_prod", obs_prod[base+1], 64991);
        chk("approx_ff_acc", obs_acc[base+1], 64998);
        chk("approx_3x5_prod", obs_prod[base+2], 15);
        chk("approx_3x5_acc", obs_acc[base+2], 65013);

        // Overflow, then a clear right behind the overflowing transaction
        base = obs_prod.size();
        send(8'd255, 8'd255, 1'b0, 1'b1);
        for (int i = 0; i < 258; i++) send(8'd255, 8'd255, 1'b0, 1'b0);
        send(8'd1, 8'd1, 1'b0, 1'b1);
        wait_obs(base + 260);
        chk("ovf_258_acc", obs_acc[base+257], 16776450);
        chk("ovf_258_flag", obs_ovf[base+257], 0);
        chk("ovf_259_acc", obs_acc[base+258], 64259);
        chk("ovf_259_flag", obs_ovf[base+258], 1);
        chk("ovf_clear_acc", obs_acc[base+259], 1);
        chk("ovf_clear_flag", obs_ovf[base+259], 0);

        // Backpressure: downstream stalls 6 cycles as the first result appears
        base = obs_prod.size();
        begin
            int s0;
            s0 = n_stall;
            st_lo = cyc + 3; st_hi = cyc + 9;
            for (int i = 1; i <= 5; i++) send(W'(i), 8'd2, 1'b0, i == 1);
            wait_obs(base + 5);
            chk("bp_stall_count", n_stall - s0, 6);
        end
        for (int i = 0; i < 5; i++) chk("bp_prod", obs_prod[base+i], 2*(i+1));
        chk("bp_final_acc", obs_acc[base+4], 30);

        // Bubble between two transactions
        base = obs_prod.size();
        send(8'd4, 8'd4, 1'b0, 1'b1);
        idle(1);
        send(8'd5, 8'd5, 1'b0, 1'b0);
        wait_obs(base + 2);
        chk("bubble_acc0", obs_acc[base], 16);
        chk("bubble_acc1", obs_acc[base+1], 41);

        // Randomized traffic with random downstream readiness
        base = obs_prod.size();
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_obs(base + 300);
        rdy_rand = 1'b0;
        idle(2);

        // Asynchronous reset with transactions in flight
        send(8'd9, 8'd9, 1'b0, 1'b0);
        send(8'd10, 8'd10, 1'b0, 1'b0);
        send(8'd11, 8'd11, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_prod", out_prod, 0);
        chk("rst_mid_acc", out_acc, 0);
        chk("rst_mid_ovf", out_ovf, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        base = obs_prod.size();
        send(8'd7, 8'd9, 1'b0, 1'b0);
        wait_obs(base + 1);
        chk("rst_after_prod", obs_prod[base], 63);
        chk("rst_after_acc", obs_acc[base], 63);
        chk("rst_after_ovf", obs_ovf[base], 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
